serial_alu_sequencer: RTL
=========================

Name: serial_alu_sequencer

Overview:
- Bit-serial ALU controller sitting directly upstream of the 1-bit ALU slice.
- Accepts a WIDTH-bit operation and drives one slice with operand bits LSB-first, one bit per clock.
- Holds the inter-bit carry in a flip-flop and consumes the slice's result/carry-out to assemble the full WIDTH-bit result.
- Reports zero, overflow and a done pulse.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- alu_op  input  3  000 AND, 001 OR, 010 ADD, 011 XOR, 110 SUB, 111 SLT; 100/101 invalid.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; result/flags valid from this cycle.
- result  output  WIDTH  final result; held until next accepted start.
- zero  output  1  result == 0; held with result.
- overflow  output  1  signed overflow for ADD/SUB/SLT, else 0.
- invalid_op  output  1  set with done for 100/101.
- slice_a  output  1  to slice in_0.
- slice_b  output  1  to slice in_1.
- slice_cin  output  1  to slice c_in.
- slice_ainvert  output  1  to slice ainvert; always 0.
- slice_binvert  output  1  to slice binvert; always 0.
- slice_less_xor  output  1  to slice less_xor.
- slice_op1  output  1  to slice Operation_1.
- slice_op0  output  1  to slice Operation_0.
- slice_result  input  1  from slice result.
- slice_cout  input  1  from slice c_out.

Behaviour:
- Reset: state IDLE. busy, done, result, zero, overflow, invalid_op and carry register all 0. Bit index 0.
- FSM states: IDLE, RUN, SLT_FIX, DONE.
- IDLE:
  - start=1 latches a, b and alu_op.
  - For SUB/SLT, latches ~b instead of b (the sequencer performs B inversion; the slice invert controls are held 0).
  - Valid op: go to RUN with index 0.
  - Invalid op: go to DONE with result=0 and invalid_op=1.
- RUN, each cycle:
  - slice_a = A[idx], slice_b = Bl[idx].
  - slice_cin = (idx==0) ? (1 for SUB/SLT, else 0) : carry_reg.
  - On the edge: result[idx] <= slice_result; carry_reg <= slice_cout.
  - Slice control: AND op1/op0=00; OR 01; ADD/SUB/SLT 10; XOR 11 with less_xor=1. less_xor=0 for all other ops.
  - Outside RUN, all slice_* outputs are 0.
- MSB cycle (idx==WIDTH-1): overflow <= slice_cin XOR slice_cout for ADD/SUB/SLT, else 0. Then go to SLT_FIX if op is SLT, otherwise DONE.
- SLT_FIX (one cycle): result <= {WIDTH-1 zeros, result[WIDTH-1] XOR overflow}. overflow keeps the subtraction's value.
- DONE (one cycle):
  - done=1, busy=0.
  - zero = (result==0), registered so it is valid together with done.
  - Return to IDLE.
- Latency from start-sampling edge to done high:
  - WIDTH+1 cycles for AND/OR/ADD/XOR/SUB.
  - WIDTH+2 cycles for SLT.
  - 1 cycle for invalid ops.
- busy is high in RUN and SLT_FIX.
- start while not in IDLE is ignored; no queuing. start in the DONE cycle is also ignored.
- A new accepted start clears invalid_op, zero and overflow. result keeps its old value until overwritten bit by bit.
- Carry wrap: the final slice_cout is discarded after the overflow calculation. ADD/SUB results are modulo 2^WIDTH.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. No done pulse for the aborted operation.

Test Plan (WIDTH=32, with a behavioural slice model):
- ADD a=0x0000_FFFF, b=0x0000_0001 -> done after 33 cycles; result=0x0001_0000, zero=0, overflow=0.
- ADD a=0x7FFF_FFFF, b=1 -> result=0x8000_0000, overflow=1. SUB a=5, b=5 -> result=0, zero=1, overflow=0.
- SLT a=0xFFFF_FFFF (-1), b=1 -> result=1 after 34 cycles. SLT a=0x8000_0000, b=1 -> result=1, overflow=1. SLT a=3, b=2 -> result=0.
- AND/OR/XOR with a=0xF0F0_1234, b=0x0FF0_FFFF -> 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB respectively; slice op/less_xor encodings checked every RUN cycle.
- alu_op=100 -> done one cycle after start, invalid_op=1, result=0. start pulsed while busy -> ignored, first operation's result unchanged.
- reset asserted at bit 10 of an ADD -> busy, done and result go to 0 immediately. Next ADD 2+3 -> result=5 with a normal 33-cycle latency.

Source files
------------

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: walks a WIDTH-bit operation through a 1-bit ALU slice
// LSB-first, carrying between bits in a flip-flop, and reports result, zero, overflow, done.
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             invalid_op,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_ainvert,
  output logic             slice_binvert,
  output logic             slice_less_xor,
  output logic             slice_op1,
  output logic             slice_op0,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_t;

  state_t           state, next_state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2:0]       op_reg;
  logic             carry;
  logic [WIDTH-1:0] result_next;

  // 100/101 are the only invalid encodings; SUB and SLT (11x) need B inverted and carry-in 1.
  logic start_valid, start_sub, op_sub, op_arith, last_bit;
  assign start_valid = !(alu_op[2] && !alu_op[1]);
  assign start_sub   = alu_op[2] && alu_op[1];
  assign op_sub      = op_reg[2] && op_reg[1];
  assign op_arith    = (op_reg == 3'b010) || op_sub;
  assign last_bit    = (idx == IW'(WIDTH - 1));

  assign busy          = (state == RUN) || (state == SLT_FIX);
  assign done          = (state == DONE);
  assign slice_ainvert = 1'b0;
  assign slice_binvert = 1'b0;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    next_state     = state;
    result_next    = result;
    slice_a        = 1'b0;
    slice_b        = 1'b0;
    slice_cin      = 1'b0;
    slice_less_xor = 1'b0;
    slice_op1      = 1'b0;
    slice_op0      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = start_valid ? RUN : DONE;
          if (!start_valid) result_next = '0;
        end
      end
      RUN: begin
        slice_a   = a_reg[idx];
        slice_b   = b_reg[idx];
        slice_cin = (idx == '0) ? op_sub : carry;
        case (op_reg)
          OP_AND:  {slice_op1, slice_op0} = 2'b00;
          OP_OR:   {slice_op1, slice_op0} = 2'b01;
          OP_XOR: begin
            {slice_op1, slice_op0} = 2'b11;
            slice_less_xor         = 1'b1;
          end
          default: {slice_op1, slice_op0} = 2'b10;
        endcase
        result_next[idx] = slice_result;
        if (last_bit) next_state = (op_reg == OP_SLT) ? SLT_FIX : DONE;
      end
      SLT_FIX: begin
        result_next = {{(WIDTH-1){1'b0}}, result[WIDTH-1] ^ overflow};
        next_state  = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      carry      <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      invalid_op <= 1'b0;
    end else begin
      state  <= next_state;
      result <= result_next;
      if (state == IDLE && start) begin
        a_reg      <= a;
        b_reg      <= start_sub ? ~b : b;
        op_reg     <= alu_op;
        idx        <= '0;
        carry      <= 1'b0;
        zero       <= 1'b0;
        overflow   <= 1'b0;
        invalid_op <= !start_valid;
      end
      if (state == RUN) begin
        carry <= slice_cout;
        idx   <= idx + 1'b1;
        if (last_bit) overflow <= op_arith && (slice_cin ^ slice_cout);
      end
      // Zero is taken from the value being written so it lines up with done.
      if (next_state == DONE) zero <= (result_next == '0);
    end
  end

endmodule
